fetch_sequencer: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction decoder/control unit.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction to the decoder for exactly one execute cycle.
- Uses the decoder's pc_sel/change outputs to compute the next PC, or to enter HALT (change=0).

---
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over req/ack and
// presents each one to the decoder for a single execute cycle.
module fetch_sequencer #(
    parameter int                  ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [15:0]       inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_sel,
    input  logic              change,
    input  logic [ADDR_W-1:0] target_addr,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (!change) begin
                    state_d = HALTED;
                end else begin
                    // Sequential increment wraps naturally at the address width.
                    pc_d = pc_sel ? target_addr : pc_q + 1'b1;
                    if (retired_q != '1) retired_d = retired_q + 1'b1;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (start) begin
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder with programmable ack delay, a
// small decoder model, and a scoreboard of expected (pc, inst) EXEC pairs.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic [15:0] inst;
    logic        inst_valid;
    logic [7:0]  pc;
    logic        pc_sel, change;
    logic [7:0]  target_addr;
    logic        halted;
    logic [15:0] retired;

    logic        s_imem_req, s_inst_valid, s_halted;
    logic [7:0]  s_imem_addr, s_pc;
    logic [15:0] s_inst;
    logic [1:0]  s_retired;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] inst;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .inst(inst), .inst_valid(inst_valid), .pc(pc),
        .pc_sel(pc_sel), .change(change), .target_addr(target_addr),
        .halted(halted), .retired(retired)
    );

    // Narrow-counter build runs in lockstep on the same inputs.
    fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .inst(s_inst), .inst_valid(s_inst_valid), .pc(s_pc),
        .pc_sel(pc_sel), .change(change), .target_addr(target_addr),
        .halted(s_halted), .retired(s_retired)
    );

    // Decoder model: Fxxx = HALT, BxTT = jump to TT, anything else sequential.
    assign change      = (inst[15:12] != 4'hF);
    assign pc_sel      = (inst[15:12] == 4'hB);
    assign target_addr = inst[7:0];

    always @(negedge clk) begin
        if (rst || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hDEAD;
            wait_cnt   = 0;
        end else if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
        end else begin
            imem_ack = 1'b0;
            wait_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (inst_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL exec_unexpected: pc=%h inst=%h with no expected entry", pc, inst);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (pc !== e.pc || inst !== e.inst) begin
                        failures++;
                        $display("FAIL exec_pair: got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e.pc, e.inst);
                    end
                end
                checks++;
                if (prev_valid) begin
                    failures++;
                    $display("FAIL valid_consecutive: got inst_valid high two cycles want single pulse");
                end
            end
            prev_valid = inst_valid;
        end
    end

    task automatic push_exp(input logic [7:0] p, input logic [15:0] w);
        exp_t e;
        e.pc = p;
        e.inst = w;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL %s_halt_timeout: got halted=%b want 1 within %0d cycles", name, halted, max_cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_scoreboard: got %0d pending entries want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if (inst !== 16'h0000) begin failures++; $display("FAIL reset_inst: got %h want 0000", inst); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (retired !== 16'h0000) begin failures++; $display("FAIL reset_retired: got %h want 0000", retired); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'h1000 + 16'(i);
            push_exp(8'(i), 16'h1000 + 16'(i));
        end
        push_exp(8'h04, 16'hF000);
        pulse_start();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            failures++; $display("FAIL seq_first_fetch: got req=%b addr=%h want req=1 addr=00", imem_req, imem_addr); end
        repeat (8) @(negedge clk);
        checks++; if (retired !== 16'd4) begin failures++; $display("FAIL seq_retired_8cyc: got %0d want 4", retired); end
        checks++; if (s_retired !== 2'b11) begin failures++; $display("FAIL seq_sat_retired: got %b want 11", s_retired); end
        wait_halt("seq", 20);
        checks++; if (pc !== 8'h04) begin failures++; $display("FAIL seq_halt_pc: got %h want 04", pc); end
    endtask

    task automatic test_halt_restart();
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF000;
        push_exp(8'h00, 16'h1001); push_exp(8'h01, 16'h1002);
        push_exp(8'h02, 16'h1003); push_exp(8'h03, 16'hF000);
        pulse_start();
        checks++; if (pc !== 8'h00 || retired !== 16'd0 || s_retired !== 2'd0 || halted !== 1'b0) begin
            failures++; $display("FAIL restart_state: got pc=%h retired=%0d sat=%0d halted=%b want 00/0/0/0", pc, retired, s_retired, halted); end
        wait_halt("halt", 20);
        checks++; if (inst !== 16'hF000) begin failures++; $display("FAIL halt_inst: got %h want F000", inst); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc !== 8'h03 || retired !== 16'd3 || imem_req !== 1'b0 || halted !== 1'b1) begin
                failures++;
                $display("FAIL halt_hold: got pc=%h retired=%0d req=%b halted=%b want 03/3/0/1", pc, retired, imem_req, halted);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_states();
        ack_delay = 2;
        mem[0] = 16'h1010; mem[1] = 16'hF000;
        push_exp(8'h00, 16'h1010); push_exp(8'h01, 16'hF000);
        // start stays high through FETCH/EXEC and must be ignored there.
        @(negedge clk) start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic       want_req, want_valid;
            logic [7:0] want_addr;
            @(negedge clk);
            want_req   = (c % 4) != 3;
            want_valid = (c % 4) == 3;
            want_addr  = (c < 4) ? 8'h00 : 8'h01;
            checks++;
            if (imem_req !== want_req || inst_valid !== want_valid || imem_addr !== want_addr) begin
                failures++;
                $display("FAIL wait_cycle%0d: got req=%b valid=%b addr=%h want req=%b valid=%b addr=%h",
                         c, imem_req, inst_valid, imem_addr, want_req, want_valid, want_addr);
            end
        end
        start = 1'b0;
        wait_halt("wait", 20);
        checks++; if (retired !== 16'd1) begin failures++; $display("FAIL wait_retired: got %0d want 1", retired); end
        ack_delay = 0;
    endtask

    task automatic test_branch();
        mem[0] = 16'hB005; mem[5] = 16'h1000; mem[6] = 16'hF000;
        push_exp(8'h00, 16'hB005); push_exp(8'h05, 16'h1000); push_exp(8'h06, 16'hF000);
        pulse_start();
        wait_halt("br_seq", 20);
        checks++; if (pc !== 8'h06) begin failures++; $display("FAIL br_seq_pc: got %h want 06", pc); end

        mem[5] = 16'hB040; mem[8'h40] = 16'hB0FF; mem[8'hFF] = 16'h1000;
        push_exp(8'h00, 16'hB005); push_exp(8'h05, 16'hB040); push_exp(8'h40, 16'hB0FF);
        push_exp(8'hFF, 16'h1000); push_exp(8'h00, 16'hF000);
        pulse_start();
        for (int i = 0; i < 20 && !(inst_valid && pc == 8'h05); i++) @(negedge clk);
        checks++;
        if (!(inst_valid === 1'b1 && pc === 8'h05)) begin
            failures++; $display("FAIL br_reach_05: got valid=%b pc=%h want 1/05", inst_valid, pc);
        end
        mem[0] = 16'hF000;
        @(negedge clk);
        checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL br_target: got %h want 40", imem_addr); end
        wait_halt("br_jmp", 30);
        checks++; if (pc !== 8'h00 || retired !== 16'd4) begin
            failures++; $display("FAIL br_wrap: got pc=%h retired=%0d want 00/4", pc, retired); end
    endtask

    task automatic test_reset_mid_fetch();
        mem[0] = 16'h1000;
        pulse_start();
        #2;
        checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b1) begin
            failures++; $display("FAIL rstmid_setup: got req=%b ack=%b want 1/1", imem_req, imem_ack); end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 8'h00 || inst !== 16'h0000 ||
            halted !== 1'b0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_async: got req=%b valid=%b pc=%h inst=%h halted=%b retired=%0d want 0/0/00/0000/0/0",
                     imem_req, inst_valid, pc, inst, halted, retired);
        end
        @(posedge clk);
        #1;
        checks++; if (inst !== 16'h0000 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_late_ack: got inst=%h valid=%b want 0000/0", inst, inst_valid); end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                failures++; $display("FAIL rstmid_idle: got req=%b valid=%b want 0/0", imem_req, inst_valid);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 6; i++) begin
            mem[i] = 16'h2000 + 16'(i);
            push_exp(8'(i), 16'h2000 + 16'(i));
        end
        mem[6] = 16'hF000;
        push_exp(8'h06, 16'hF000);
        pulse_start();
        wait_halt("sat", 40);
        checks++; if (retired !== 16'd6) begin failures++; $display("FAIL sat_wide: got %0d want 6", retired); end
        checks++; if (s_retired !== 2'b11) begin failures++; $display("FAIL sat_narrow: got %b want 11", s_retired); end
        checks++; if (pc !== 8'h06) begin failures++; $display("FAIL sat_pc: got %h want 06", pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        test_reset();
        test_sequential();
        test_halt_restart();
        test_wait_states();
        test_branch();
        test_reset_mid_fetch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
